// File: rtl/jk_counter_pkg.sv
// Shared definitions for the JK-flip-flop counter library: direction encoding
// and the modulus/width legality helper used at elaboration.
package jk_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Number of bits needed to hold every count value 0..m-1 (minimum 1).
  function automatic int unsigned clog2_mod(input longint unsigned m);
    int unsigned     n;
    longint unsigned v;
    n = 0;
    v = (m == 0) ? 64'd0 : m - 64'd1;
    while (v != 0) begin
      n++;
      v = v >> 1;
    end
    if (n == 0) n = 1;
    return n;
  endfunction

endpackage

// File: rtl/jk_ff.sv
// Single JK flip-flop with synchronous active-low reset to 0.
module jk_ff (
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_d;
  logic q_q;

  // Characteristic equation: set on J, clear on K, toggle on both.
  always_comb begin
    q_d = (j & ~q_q) | (~k & q_q);
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) q_q <= 1'b0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/jk_updown_counter_n.sv
// Parametrised mod-N up/down counter built from discrete JK flip-flops.
// Optional build macro JK_COUNTER_SATURATE_EN: hold at the end of range
// instead of wrapping (wrap then never pulses; tc still asserts).
module jk_updown_counter_n
  import jk_counter_pkg::*;
#(
  parameter int unsigned     WIDTH   = 8,
  parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             ud,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             tc,
  output logic             wrap
);

  if (WIDTH < 1 || MODULUS < 2 || clog2_mod(MODULUS) > WIDTH) begin : g_bad_params
    $error("jk_updown_counter_n: need WIDTH>=1 and 2 <= MODULUS <= 2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 64'd1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] next_val;
  logic [WIDTH-1:0] toggle;
  logic             at_max;
  logic             at_zero;
  logic             out_of_range;
  logic             wrap_d;
  logic             wrap_q;

  // Next-count selection (load > en > hold); the flops only ever see the
  // resulting toggle mask through J/K, never the value itself.
  always_comb begin
    at_max       = (q == MAX);
    at_zero      = (q == '0);
    out_of_range = (q > MAX);
    next_val     = q;
    wrap_d       = 1'b0;
    if (load) begin
      next_val = (load_val > MAX) ? MAX : load_val;
    end else if (en) begin
      if (out_of_range) begin
        next_val = '0;
      end else if (ud == DIR_UP) begin
        if (at_max) begin
`ifdef JK_COUNTER_SATURATE_EN
          next_val = MAX;
`else
          next_val = '0;
          wrap_d   = 1'b1;
`endif
        end else begin
          next_val = q + ONE;
        end
      end else begin
        if (at_zero) begin
`ifdef JK_COUNTER_SATURATE_EN
          next_val = '0;
`else
          next_val = MAX;
          wrap_d   = 1'b1;
`endif
        end else begin
          next_val = q - ONE;
        end
      end
    end
    toggle = q ^ next_val;
    tc     = en & ~load & ((ud & at_max) | (~ud & at_zero));
  end

  assign j = toggle;
  assign k = toggle;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_ff u_ff (
      .clk   (clk),
      .rst_n (rst_n),
      .j     (j[i]),
      .k     (k[i]),
      .q     (q[i])
    );
  end

  // Rollover flag, one cycle wide, aligned with the wrapped count.
  always_ff @(posedge clk) begin
    if (!rst_n) wrap_q <= 1'b0;
    else        wrap_q <= wrap_d;
  end

  assign wrap = wrap_q;

endmodule

// File: tb/tb_jk_updown_counter_n.sv
// Scoreboard bench for jk_updown_counter_n (WIDTH=4, MODULUS=10).
module tb_jk_updown_counter_n;

  localparam int W   = 4;
  localparam int MOD = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         ud = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] q;
  logic [W-1:0] j;
  logic [W-1:0] k;
  logic         tc;
  logic         wrap;

  jk_updown_counter_n #(.WIDTH(W), .MODULUS(MOD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .ud       (ud),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .j        (j),
    .k        (k),
    .tc       (tc),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit chk_comb;
    int q;
    int wrap;
    int tc;
    int jk;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cnt   = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: count is an integer in 0..MOD-1 advanced with modular arithmetic.
  task automatic step(input bit r, input bit e, input bit u, input bit l, input int lv);
    exp_t x;
    int   nxt;
    int   w;
    @(negedge clk);
    rst_n = r; en = e; ud = u; load = l; load_val = lv[W-1:0];
    w   = 0;
    nxt = cnt;
    if (l) begin
      nxt = (lv[W-1:0] >= MOD) ? MOD - 1 : int'(lv[W-1:0]);
    end else if (e) begin
      if (u) begin
`ifdef JK_COUNTER_SATURATE_EN
        nxt = (cnt == MOD - 1) ? cnt : cnt + 1;
`else
        nxt = (cnt + 1) % MOD;
        w   = (cnt == MOD - 1) ? 1 : 0;
`endif
      end else begin
`ifdef JK_COUNTER_SATURATE_EN
        nxt = (cnt == 0) ? 0 : cnt - 1;
`else
        nxt = (cnt + MOD - 1) % MOD;
        w   = (cnt == 0) ? 1 : 0;
`endif
      end
    end
    x.chk_comb = r;
    x.tc       = (e && !l && ((u && cnt == MOD - 1) || (!u && cnt == 0))) ? 1 : 0;
    x.jk       = cnt ^ nxt;
    if (!r) begin
      nxt = 0;
      w   = 0;
    end
    x.q    = nxt;
    x.wrap = w;
    cnt    = nxt;
    sb.push_back(x);
  endtask

  // Monitor: sample combinational outputs mid-cycle, registered ones after the edge.
  initial begin
    exp_t x;
    int   tc_s, j_s, k_s;
    forever begin
      @(negedge clk);
      #2;
      tc_s = int'(tc);
      j_s  = int'(j);
      k_s  = int'(k);
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        x = sb.pop_front();
        chk("q", int'(q), x.q);
        chk("wrap", int'(wrap), x.wrap);
        if (x.chk_comb) begin
          chk("tc", tc_s, x.tc);
          chk("j", j_s, x.jk);
          chk("k", k_s, x.jk);
        end
      end
    end
  end

  initial begin
    // Reset with load/en active
    step(0, 1, 1, 1, 7);
    step(0, 1, 1, 1, 7);
    // Decade up-count through wrap
    for (int i = 0; i < 12; i++) step(1, 1, 1, 0, 0);
    // Load 2 then count down through wrap
    step(1, 0, 1, 1, 2);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0);
    // Load priority over en, clamp of out-of-range load value
    step(1, 1, 1, 1, 13);
    step(1, 1, 0, 1, 4);
    step(1, 1, 1, 1, 15);
    // Hold at 5, then flip direction every edge
    step(1, 0, 1, 1, 5);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, (i % 2 == 0), 0, 0);
    // Reset mid-count overrides load and en
    step(1, 1, 1, 1, 8);
    step(0, 1, 1, 1, 3);
    // Randomised traffic
    repeat (400) begin
      step(($urandom % 50) != 0, ($urandom % 4) != 0, $urandom % 2 == 1,
           ($urandom % 10) == 0, int'($urandom % 16));
    end
    step(1, 0, 1, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
